mem_port_arbiter: RTL and testbench

- Shares one single-ported backing memory between the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each access with a req/ack handshake toward the memory.
- Generates per-stage stall signals so the pipeline freezes while its access is pending.
- Sits between the pipeline (PC/IF_ID and EX_MEM/MEM_WB) and a shared memory model.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline fetch/data ports and shared memory port of the arbiter
interface mem_port_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_stall_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        d_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        busy_o;
    logic        err_o;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
        output if_rdata_o, if_ack_o, if_stall_o, d_rdata_o, d_ack_o, d_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
        input  if_rdata_o, if_ack_o, if_stall_o, d_rdata_o, d_ack_o, d_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store with starvation guard
// Optional BUSY abort with sticky err_o when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic          owner_d;
    logic [SW-1:0] starve_cnt;
    logic          grant_d, grant_i;
    logic          timeout_hit;
    logic          complete;
    logic [31:0]   rdata_in;

    // Data wins ties unless fetch has already waited out STARVE_LIMIT data grants.
    assign grant_d  = bus.d_req_i && !(bus.if_req_i && starve_cnt == SW'(STARVE_LIMIT));
    assign grant_i  = bus.if_req_i && !grant_d;
    assign complete = (state == BUSY) && (bus.mem_ack_i || timeout_hit);
    assign rdata_in = bus.mem_ack_i ? bus.mem_rdata_i : 32'hDEADBEEF;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          err_q;

    // A real ack in the final cycle takes priority over the abort.
    assign timeout_hit = (state == BUSY) && !bus.mem_ack_i && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == BUSY && !complete) to_cnt <= to_cnt + 1'b1;
            else                            to_cnt <= '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
    assign bus.err_o = err_q;
`else
    // Without the abort path BUSY waits for the memory indefinitely.
    assign timeout_hit = (TIMEOUT < 0);
    assign bus.err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_i) state_nxt = BUSY;
            BUSY:    if (complete) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_d         <= 1'b0;
            starve_cnt      <= '0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.if_rdata_o  <= '0;
            bus.d_rdata_o   <= '0;
            bus.if_ack_o    <= 1'b0;
            bus.d_ack_o     <= 1'b0;
        end else begin
            bus.if_ack_o <= 1'b0;
            bus.d_ack_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d         <= 1'b1;
                        bus.mem_req_o   <= 1'b1;
                        bus.mem_we_o    <= bus.d_we_i;
                        bus.mem_addr_o  <= bus.d_addr_i;
                        bus.mem_wdata_o <= bus.d_wdata_i;
                        if (!bus.if_req_i)                         starve_cnt <= '0;
                        else if (starve_cnt < SW'(STARVE_LIMIT))   starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_i) begin
                        owner_d         <= 1'b0;
                        bus.mem_req_o   <= 1'b1;
                        bus.mem_we_o    <= 1'b0;
                        bus.mem_addr_o  <= bus.if_addr_i;
                        bus.mem_wdata_o <= '0;
                        starve_cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (complete) begin
                        bus.mem_req_o <= 1'b0;
                        if (owner_d) begin
                            bus.d_ack_o <= 1'b1;
                            if (!bus.mem_we_o) bus.d_rdata_o <= rdata_in;
                        end else begin
                            bus.if_ack_o   <= 1'b1;
                            bus.if_rdata_o <= rdata_in;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o     = (state != IDLE);
    assign bus.if_stall_o = bus.if_req_i & ~bus.if_ack_o;
    assign bus.d_stall_o  = bus.d_req_i & ~bus.d_ack_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table, directed corner sequences and random traffic vs transaction model
module tb_mem_port_arbiter;
    localparam int SL = 4;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          has_val;
        logic [31:0] mem_val;
        int          lat;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    int tests = 0, fails = 0;
    logic [31:0] memm [logic [31:0]];

    int          sc;
    bit          own_v, own_d, err_exp, prev_req;
    logic [31:0] g_addr, g_wdata, exp_val, exp_if_rd, exp_d_rd;
    logic        g_we;
    int          bcnt, idle_run, last_gap;
    bit          grants_q[$];
    int          if_ack_seen = 0, d_ack_seen = 0;
    int          rcnt, cur_lat, lat_cfg = 1;
    bit          rand_lat, silent, stray_en, resp_acked;
    bit          auto_if, auto_d;
    int          p_if, p_d;

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (memm.exists(a)) return memm[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit rise, mack_busy, to_hit, ack_any, exp_ack;
        logic [31:0] v;
        if (rst) begin
            chk("rst_mem_req", bus.mem_req_o, 0);   chk("rst_mem_we", bus.mem_we_o, 0);
            chk("rst_mem_addr", bus.mem_addr_o, 0); chk("rst_mem_wdata", bus.mem_wdata_o, 0);
            chk("rst_if_rdata", bus.if_rdata_o, 0); chk("rst_d_rdata", bus.d_rdata_o, 0);
            chk("rst_acks", {bus.if_ack_o, bus.d_ack_o}, 0);
            chk("rst_busy", bus.busy_o, 0);         chk("rst_err", bus.err_o, 0);
            sc = 0; own_v = 0; err_exp = 0; prev_req = 0; bcnt = 0;
            exp_if_rd = 0; exp_d_rd = 0;
            return;
        end
        rise      = bus.mem_req_o && !prev_req;
        mack_busy = bus.mem_ack_i && prev_req;
        to_hit    = TO_EN && own_v && (bcnt == TO) && !mack_busy;
        if (rise) begin
            chk("grant_has_req", bus.if_req_i | bus.d_req_i, 1);
            own_d = bus.d_req_i && !(bus.if_req_i && sc == SL);
            if (own_d) begin
                chk("grant_d_addr", bus.mem_addr_o, bus.d_addr_i);
                chk("grant_d_we", bus.mem_we_o, bus.d_we_i);
                chk("grant_d_wdata", bus.mem_wdata_o, bus.d_wdata_i);
                if (bus.d_we_i) memm[bus.d_addr_i] = bus.d_wdata_i;
                exp_val = bus.d_we_i ? 32'h0 : mrd(bus.d_addr_i);
                sc = bus.if_req_i ? ((sc < SL) ? sc + 1 : sc) : 0;
            end else begin
                chk("grant_i_addr", bus.mem_addr_o, bus.if_addr_i);
                chk("grant_i_we", bus.mem_we_o, 0);
                chk("grant_i_wdata", bus.mem_wdata_o, 0);
                exp_val = mrd(bus.if_addr_i);
                sc = 0;
            end
            g_addr = bus.mem_addr_o; g_we = bus.mem_we_o; g_wdata = bus.mem_wdata_o;
            own_v = 1; grants_q.push_back(own_d);
            rcnt = 0; resp_acked = 0;
            cur_lat = rand_lat ? $urandom_range(1, 5) : lat_cfg;
        end else if (bus.mem_req_o) begin
            chk("stable_addr", bus.mem_addr_o, g_addr);
            chk("stable_we", bus.mem_we_o, g_we);
            chk("stable_wdata", bus.mem_wdata_o, g_wdata);
        end
        ack_any = bus.if_ack_o | bus.d_ack_o;
        exp_ack = own_v && (mack_busy || to_hit);
        chk("ack_timing", ack_any, exp_ack);
        chk("busy", bus.busy_o, own_v);
        if (ack_any && own_v) begin
            chk("ack_port", bus.d_ack_o, own_d);
            chk("ack_single", bus.if_ack_o & bus.d_ack_o, 0);
            chk("ack_req_low", bus.mem_req_o, 0);
            v = to_hit ? 32'hDEADBEEF : exp_val;
            if (own_d) begin
                if (!g_we) exp_d_rd = v;
                d_ack_seen++;
            end else begin
                exp_if_rd = v;
                if_ack_seen++;
            end
            if (to_hit) err_exp = 1;
            chk("if_rdata", bus.if_rdata_o, exp_if_rd);
            chk("d_rdata", bus.d_rdata_o, exp_d_rd);
            chk("err", bus.err_o, err_exp);
            own_v = 0;
        end
        chk("if_stall", bus.if_stall_o, bus.if_req_i & ~bus.if_ack_o);
        chk("d_stall", bus.d_stall_o, bus.d_req_i & ~bus.d_ack_o);
        if (bus.busy_o) begin
            if (idle_run > 0) last_gap = idle_run;
            idle_run = 0;
        end else idle_run++;
        bcnt = bus.mem_req_o ? bcnt + 1 : 0;
        prev_req = bus.mem_req_o;
    endtask

    task automatic drive();
        if (bus.if_ack_o) bus.if_req_i = 1'b0;
        if (bus.d_ack_o)  bus.d_req_i  = 1'b0;
        if (auto_if && !bus.if_req_i && $urandom_range(0, 99) < p_if) begin
            bus.if_req_i = 1'b1; bus.if_addr_i = $urandom & 32'hFC;
        end
        if (auto_d && !bus.d_req_i && $urandom_range(0, 99) < p_d) begin
            bus.d_req_i = 1'b1; bus.d_we_i = 1'($urandom_range(0, 1));
            bus.d_addr_i = $urandom & 32'hFC; bus.d_wdata_i = $urandom;
        end
        if (bus.mem_req_o && !resp_acked) begin
            rcnt++;
            if (!silent && rcnt >= cur_lat) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = bus.mem_we_o ? ~bus.mem_wdata_o : mrd(bus.mem_addr_o);
                resp_acked = 1;
            end else bus.mem_ack_i = 1'b0;
        end else if (!bus.mem_req_o && stray_en && $urandom_range(0, 9) == 0) begin
            bus.mem_ack_i = 1'b1; bus.mem_rdata_i = $urandom;
        end else bus.mem_ack_i = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic reset_dut(input bit clear_req);
        if (clear_req) begin bus.if_req_i = 1'b0; bus.d_req_i = 1'b0; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic access(input string nm, input vec_t v);
        int cyc, base;
        if (v.has_val) memm[v.addr] = v.mem_val;
        lat_cfg = v.lat; rand_lat = 0;
        if (v.is_d) begin
            bus.d_req_i = 1'b1; bus.d_we_i = v.we; bus.d_addr_i = v.addr; bus.d_wdata_i = v.wdata;
            base = d_ack_seen;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = v.addr;
            base = if_ack_seen;
        end
        cyc = 0;
        while (((v.is_d ? d_ack_seen : if_ack_seen) == base) && cyc < 40) begin
            tick(); cyc++;
        end
        chk({nm, "_ack_cycle"}, cyc, v.exp_cyc);
        chk({nm, "_rdata"}, v.is_d ? bus.d_rdata_o : bus.if_rdata_o, v.exp_rdata);
        chk({nm, "_mem_we"}, g_we, v.exp_we);
        chk({nm, "_mem_wdata"}, g_wdata, v.exp_wdata);
        tick();
    endtask

    vec_t vecs[5];
    bit   exp_order[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        vec_t tv;
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.d_req_i = 0; bus.d_we_i = 0;
        bus.d_addr_i = 0; bus.d_wdata_i = 0; bus.mem_rdata_i = 0; bus.mem_ack_i = 0;
        auto_if = 0; auto_d = 0; p_if = 0; p_d = 0; silent = 0; stray_en = 0; rand_lat = 0;
        idle_run = 0; last_gap = 0;

        vecs[0] = '{0, 0, 32'h40, 32'h0,        1, 32'h8C220004, 2, 3, 32'h8C220004, 1'b0, 32'h0};
        vecs[1] = '{1, 1, 32'h10, 32'h12345678, 0, 32'h0,        1, 2, 32'h0,        1'b1, 32'h12345678};
        vecs[2] = '{1, 0, 32'h10, 32'h0,        0, 32'h0,        3, 4, 32'h12345678, 1'b0, 32'h0};
        vecs[3] = '{0, 0, 32'h44, 32'h0,        1, 32'h3C01ABCD, 7, 8, 32'h3C01ABCD, 1'b0, 32'h0};
        vecs[4] = '{1, 0, 32'h80, 32'h0,        1, 32'hCAFEF00D, 1, 2, 32'hCAFEF00D, 1'b0, 32'h0};
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) access($sformatf("vec%0d", i), vecs[i]);

        // Both requesters held continuously: D x4, then I, repeating.
        reset_dut(1);
        grants_q.delete();
        rand_lat = 1; p_if = 100; p_d = 100; auto_if = 1; auto_d = 1;
        n = 0;
        while (grants_q.size() < 10 && n < 300) begin tick(); n++; end
        auto_if = 0; auto_d = 0;
        chk("starve_grants", grants_q.size() >= 10, 1);
        for (int i = 0; i < 10 && i < grants_q.size(); i++)
            chk($sformatf("starve_order%0d", i), grants_q[i], exp_order[i]);
        n = 0;
        while ((bus.if_req_i || bus.d_req_i || bus.busy_o) && n < 60) begin tick(); n++; end

        // Back-to-back data accesses with 7-cycle memory latency.
        rand_lat = 0; lat_cfg = 7; p_d = 100; auto_d = 1;
        base = d_ack_seen; n = 0;
        while (d_ack_seen == base && n < 60) begin tick(); n++; end
        last_gap = -1;
        while (d_ack_seen < base + 2 && n < 60) begin tick(); n++; end
        auto_d = 0;
        chk("b2b_acks", d_ack_seen - base, 2);
        chk("b2b_busy_gap", last_gap, 1);
        n = 0;
        while ((bus.d_req_i || bus.busy_o) && n < 60) begin tick(); n++; end

        // Reset in the second BUSY cycle of a load, then the held request is served.
        reset_dut(1);
        lat_cfg = 10;
        bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h20; bus.d_wdata_i = 32'h0;
        n = 0;
        while (!bus.mem_req_o && n < 10) begin tick(); n++; end
        chk("rstmid_busy_seen", bus.mem_req_o, 1);
        tick();
        base = d_ack_seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_no_ack", d_ack_seen, base);
        lat_cfg = 2; n = 0;
        while (d_ack_seen == base && n < 20) begin tick(); n++; end
        chk("rstmid_served", d_ack_seen, base + 1);
        chk("rstmid_rdata", bus.d_rdata_o, mrd(32'h20));
        tick();

`ifdef ARB_TIMEOUT_EN
        reset_dut(1);
        silent = 1;
        tv = '{1, 0, 32'h30, 32'h0, 1, 32'h11112222, 1, 9, 32'hDEADBEEF, 1'b0, 32'h0};
        access("timeout", tv);
        chk("timeout_err_set", bus.err_o, 1);
        silent = 0;
        tv = '{1, 0, 32'h34, 32'h0, 1, 32'h33334444, 2, 3, 32'h33334444, 1'b0, 32'h0};
        access("after_timeout", tv);
        chk("timeout_err_sticky", bus.err_o, 1);
`else
        tv = '{0, 0, 32'h48, 32'h0, 1, 32'h55556666, 2, 3, 32'h55556666, 1'b0, 32'h0};
        access("err_off", tv);
        chk("err_tied_low", bus.err_o, 0);
`endif

        // Random traffic with stray memory acks outside BUSY.
        reset_dut(1);
        rand_lat = 1; stray_en = 1; p_if = 35; p_d = 45; auto_if = 1; auto_d = 1;
        for (int i = 0; i < 3000; i++) tick();
        auto_if = 0; auto_d = 0;
        n = 0;
        while ((bus.if_req_i || bus.d_req_i || bus.busy_o) && n < 60) begin tick(); n++; end
        stray_en = 0;
        tick(); tick();
        chk("random_drained", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
